// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and pipeline-register bubble values.
// Imported by every pipeline register stage.
package y86_pkg;

  // One-hot instruction status
  localparam logic [3:0] STAT_AOK = 4'b0001;
  localparam logic [3:0] STAT_HLT = 4'b0010;
  localparam logic [3:0] STAT_ADR = 4'b0100;
  localparam logic [3:0] STAT_INS = 4'b1000;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  // Narrow control fields carried by every pipeline register
  typedef struct packed {
    logic [3:0] status;
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] rA;
    logic [3:0] rB;
  } ctrlFieldsT;

  localparam ctrlFieldsT BUBBLE_CTRL = '{
    status: STAT_AOK,
    icode:  I_NOP,
    ifun:   4'h0,
    rA:     RNONE,
    rB:     RNONE
  };

endpackage

// File: rtl/pc_select.sv
// Fetch PC selection (mispredict > return > prediction) and next-PC prediction.
module pc_select
  import y86_pkg::*;
#(
  parameter int unsigned PC_W = 64
) (
  input  logic [PC_W-1:0] predPc,
  input  logic [3:0]      fIcode,
  input  logic [PC_W-1:0] fValC,
  input  logic [PC_W-1:0] fValP,
  input  logic [3:0]      mIcode,
  input  logic            mCnd,
  input  logic [PC_W-1:0] mValA,
  input  logic [3:0]      wIcode,
  input  logic [PC_W-1:0] wValM,
  output logic [PC_W-1:0] fetchPc,
  output logic [PC_W-1:0] nextPredPc
);

  always_comb begin
    fetchPc = predPc;
    if (mIcode == I_JXX && !mCnd) begin
      fetchPc = mValA;
    end else if (wIcode == I_RET) begin
      fetchPc = wValM;
    end
  end

  // Jumps and calls are predicted taken
  always_comb begin
    nextPredPc = fValP;
    if (fIcode == I_JXX || fIcode == I_CALL) begin
      nextPredPc = fValC;
    end
  end

endmodule

// File: rtl/fetch_decode_reg.sv
// F (predicted PC) and D (fetch->decode) pipeline registers with
// stall/bubble control and fetch PC selection.
module fetch_decode_reg
  import y86_pkg::*;
#(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            F_stall,
  input  logic            D_stall,
  input  logic            D_bubble,
  input  logic [3:0]      f_status,
  input  logic [3:0]      f_icode,
  input  logic [3:0]      f_ifun,
  input  logic [3:0]      f_rA,
  input  logic [3:0]      f_rB,
  input  logic [PC_W-1:0] f_valC,
  input  logic [PC_W-1:0] f_valP,
  input  logic [3:0]      M_icode,
  input  logic            M_Cnd,
  input  logic [PC_W-1:0] M_valA,
  input  logic [3:0]      W_icode,
  input  logic [PC_W-1:0] W_valM,
  output logic [PC_W-1:0] f_pc,
  output logic [PC_W-1:0] F_predPC,
  output logic [3:0]      d_status,
  output logic [3:0]      d_icode,
  output logic [3:0]      d_ifun,
  output logic [3:0]      d_rA,
  output logic [3:0]      d_rB,
  output logic [PC_W-1:0] d_valC,
  output logic [PC_W-1:0] d_valP
);

  logic [PC_W-1:0] nextPredPc;
  ctrlFieldsT      dCtrl;
  ctrlFieldsT      fCtrl;

  assign fCtrl = '{status: f_status, icode: f_icode, ifun: f_ifun, rA: f_rA, rB: f_rB};

  pc_select #(.PC_W(PC_W)) u_pcSelect (
    .predPc     (F_predPC),
    .fIcode     (f_icode),
    .fValC      (f_valC),
    .fValP      (f_valP),
    .mIcode     (M_icode),
    .mCnd       (M_Cnd),
    .mValA      (M_valA),
    .wIcode     (W_icode),
    .wValM      (W_valM),
    .fetchPc    (f_pc),
    .nextPredPc (nextPredPc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      F_predPC <= RESET_PC;
    end else if (!F_stall) begin
      F_predPC <= nextPredPc;
    end
  end

  // Stall beats bubble when both are requested
  always_ff @(posedge clk) begin
    if (reset) begin
      dCtrl  <= BUBBLE_CTRL;
      d_valC <= '0;
      d_valP <= '0;
    end else if (D_stall) begin
      dCtrl  <= dCtrl;
      d_valC <= d_valC;
      d_valP <= d_valP;
    end else if (D_bubble) begin
      dCtrl  <= BUBBLE_CTRL;
      d_valC <= '0;
      d_valP <= '0;
    end else begin
      dCtrl  <= fCtrl;
      d_valC <= f_valC;
      d_valP <= f_valP;
    end
  end

  assign d_status = dCtrl.status;
  assign d_icode  = dCtrl.icode;
  assign d_ifun   = dCtrl.ifun;
  assign d_rA     = dCtrl.rA;
  assign d_rB     = dCtrl.rB;

endmodule

// File: doc/fetch_decode_reg.md
Name: fetch_decode_reg

Overview:
- Front-end pipeline register pair for the Y86-64 pipelined processor: the F register (predicted PC) and the D register (fetch→decode latch).
- Produces the d_* bundle that execute_reg consumes, and selects the next fetch PC from prediction, mispredict and return paths.
- Applies stall and bubble control from the pipeline control unit.

Parameters:
- PC_W, 64, width of PC/valC/valP.
- RESET_PC, 64'd0, F_predPC value after reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- F_stall  input  1  hold F register
- D_stall  input  1  hold D register
- D_bubble  input  1  load nop into D register
- f_status  input  4  fetch status (one-hot)
- f_icode  input  4  fetched icode
- f_ifun  input  4  fetched ifun
- f_rA  input  4  fetched rA (4'hF = none)
- f_rB  input  4  fetched rB
- f_valC  input  PC_W  fetched constant
- f_valP  input  PC_W  fetched PC increment
- M_icode  input  4  memory-stage icode
- M_Cnd  input  1  memory-stage branch condition
- M_valA  input  PC_W  fall-through PC of a mispredicted jXX
- W_icode  input  4  write-back-stage icode
- W_valM  input  PC_W  return address from ret
- f_pc  output  PC_W  PC to fetch this cycle (combinational)
- F_predPC  output  PC_W  registered predicted PC
- d_status  output  4  D-register status
- d_icode  output  4
- d_ifun  output  4
- d_rA  output  4
- d_rB  output  4
- d_valC  output  PC_W
- d_valP  output  PC_W

Behaviour:
- Constants: STAT_AOK=4'b0001, STAT_HLT=4'b0010, STAT_ADR=4'b0100, STAT_INS=4'b1000; I_NOP=4'h1, I_JXX=4'h7, I_CALL=4'h8, I_RET=4'h9; RNONE=4'hF.
- PC select (combinational), priority order:
  - M_icode==I_JXX && !M_Cnd → M_valA.
  - Else W_icode==I_RET → W_valM.
  - Else F_predPC.
- Next prediction:
  - f_icode ∈ {I_JXX, I_CALL} → f_valC.
  - Otherwise → f_valP.
- F register, rising edge:
  - reset → RESET_PC.
  - Else F_stall → hold.
  - Else → next prediction.
- D register, rising edge, priority reset > D_stall > D_bubble > load:
  - reset → bubble.
  - D_stall → hold all fields.
  - D_bubble → bubble.
  - Otherwise latch all f_* fields.
  - Bubble values: status=STAT_AOK, icode=I_NOP, ifun=0, rA=rB=RNONE, valC=0, valP=0.
- D_stall and D_bubble asserted together: stall wins, D holds. This is legal and is not an error.
- Reset outputs: F_predPC=RESET_PC; D outputs = bubble values. f_pc after reset = RESET_PC unless M/W override inputs are active.
- Latency:
  - One cycle f_* → d_*.
  - f_pc has zero latency from M/W inputs and F_predPC.
- Reset asserted mid-stall: reset dominates, D becomes bubble and F becomes RESET_PC in the same edge.
- Status is passed through unmodified. Non-AOK statuses are latched like any other field. Halting is the control unit's job.
- No arithmetic besides muxing. Widths are fixed and there is no wrap logic; valP overflow is the fetch unit's concern.

Decomposition:
- Shared package y86_pkg holds:
  - status codes;
  - icode constants (I_HALT..I_POPQ);
  - RNONE;
  - bubble field values.
- Other pipeline registers (execute_reg, memory, write-back) import y86_pkg.
- One natural sub-module: pc_select (combinational PC select + prediction mux). The F and D registers stay in the top module.

Test Plan:
1. Reset: assert reset 1 cycle → F_predPC=0, d_icode=4'h1, d_rA=d_rB=4'hF, d_status=4'b0001, d_valC=d_valP=0.
2. Normal load: f_icode=4'h6, f_ifun=0, f_rA=f_rB=4'h6, f_valC=100, f_valP=64 → after 1 edge d_* match; F_predPC=64.
3. Prediction: f_icode=4'h7, f_valC=200, f_valP=73 → F_predPC=200, f_pc=200 next cycle. Then drive M_icode=7, M_Cnd=0, M_valA=73 → f_pc=73 combinationally.
4. Return: W_icode=9, W_valM=0x1234, with M_icode=7, M_Cnd=0 also set → f_pc=M_valA, showing mispredict priority. Clear M → f_pc=0x1234.
5. Stall/bubble:
   - D holds irmovq (icode 3, valC=5).
   - D_stall=1 with changed f_* → d_* unchanged.
   - D_stall=D_bubble=1 → still held.
   - D_bubble only → nop bubble.
   - F_stall=1 → F_predPC held.
6. Mid-operation reset: reset during D_stall=1 → next edge D is bubble and F_predPC=0. After reset deasserts, normal load resumes on the first edge.
